// File: rtl/rs_latch_sequencer.sv
// rs_latch_sequencer: arbitrates set/clear requests into fixed-width active-low
// pulses on notS/notR of an rs_flipflop. Each pulse is followed by a recovery gap
// and a one-cycle acknowledge. notS and notR are never low together, and both
// return high the moment nReset asserts.
//
// Optional feature macro: READBACK_CHECK_EN (Q readback compare, sticky err).
//
// Ports:
//   Clock    - system clock, rising edge
//   nReset   - asynchronous active-low reset
//   set_req  - set request (level, held until set_ack)
//   clr_req  - clear request (level, held until clr_ack)
//   Q        - rs_flipflop output readback
//   notS     - active-low set drive
//   notR     - active-low reset drive
//   set_ack  - one-cycle pulse, set complete
//   clr_ack  - one-cycle pulse, clear complete
//   busy     - high whenever the sequencer is not idle
//   err      - sticky readback mismatch flag
module rs_latch_sequencer #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic Clock,
    input  logic nReset,
    input  logic set_req,
    input  logic clr_req,
    input  logic Q,
    output logic notS,
    output logic notR,
    output logic set_ack,
    output logic clr_ack,
    output logic busy,
    output logic err
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          last_set;   // 1: set was served last, 0: clear was served last

`ifndef READBACK_CHECK_EN
    logic unused_q;
    assign unused_q = Q;
`endif

    // State machine and registered outputs. Outputs are a registered decode of
    // the current state, so each drive follows its state by one cycle and only
    // one pulse state can ever be decoded at a time.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            count    <= '0;
            last_set <= 1'b0;
            notS     <= 1'b1;
            notR     <= 1'b1;
            set_ack  <= 1'b0;
            clr_ack  <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            notS    <= (state != PULSE_S);
            notR    <= (state != PULSE_R);
            busy    <= (state != IDLE);
            set_ack <= (state == GAP) && (count == '0) && last_set;
            clr_ack <= (state == GAP) && (count == '0) && !last_set;

`ifdef READBACK_CHECK_EN
            // Q is checked in the ack cycle against the value just written.
            if ((set_ack && !Q) || (clr_ack && Q)) begin
                err <= 1'b1;
            end
`else
            err <= 1'b0;
`endif

            case (state)
                IDLE: begin
                    // On a tie, serve the type opposite to the last one served.
                    if (set_req && (!clr_req || !last_set)) begin
                        state    <= PULSE_S;
                        count    <= CW'(PULSE_CYCLES - 1);
                        last_set <= 1'b1;
                    end else if (clr_req) begin
                        state    <= PULSE_R;
                        count    <= CW'(PULSE_CYCLES - 1);
                        last_set <= 1'b0;
                    end
                end
                PULSE_S, PULSE_R: begin
                    if (count == '0) begin
                        state <= GAP;
                        count <= CW'(GAP_CYCLES - 1);
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                GAP: begin
                    if (count == '0) begin
                        state <= IDLE;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/rs_latch_sequencer.md
Name: rs_latch_sequencer

Overview:
Synchronous controller that drives the active-low notS/notR inputs of an rs_flipflop from two independent requesters (set and clear). It arbitrates between them and issues a fixed-width active-low pulse on exactly one input. It then enforces a recovery gap with both inputs high and acknowledges the requester. It guarantees the forbidden notS=notR=0 condition never occurs, including across reset.

Parameters:
PULSE_CYCLES, 4, clock cycles notS/notR held low per operation (legal range 1..15)
GAP_CYCLES, 2, clock cycles both outputs held high after a pulse before the next operation (legal range 1..15)

Ports:
Clock  input  1  system clock, all state updates on rising edge
nReset  input  1  asynchronous active-low reset
set_req  input  1  set request, level, held until set_ack
clr_req  input  1  clear request, level, held until clr_ack
Q  input  1  rs_flipflop output, readback
notS  output  1  active-low set drive to rs_flipflop
notR  output  1  active-low reset drive to rs_flipflop
set_ack  output  1  one-cycle pulse, set operation complete
clr_ack  output  1  one-cycle pulse, clear operation complete
busy  output  1  high in any state other than IDLE
err  output  1  sticky readback mismatch flag

Behaviour:
- One clock. Reset is asynchronous and active-low. Ports are named Clock and nReset.
- Reset values: notS=1, notR=1, set_ack=0, clr_ack=0, busy=0, err=0, state=IDLE, counter=0, last_served=CLR. Asserting nReset mid-pulse forces notS/notR high immediately, without waiting for a clock edge.
- All outputs are registered. notS and notR are never low in the same cycle.
- Counter width is 4 bits.
- FSM states: IDLE, PULSE_S, PULSE_R, GAP.
- IDLE:
  - Only set_req → PULSE_S.
  - Only clr_req → PULSE_R.
  - Both → the type opposite to last_served. After reset the first tie goes to set.
  - Neither → stay in IDLE.
- On entry to PULSE_x: notx goes low, counter loads PULSE_CYCLES-1, last_served is updated.
- PULSE_x: counter decrements each cycle. When counter==0 → GAP, notx goes high, counter loads GAP_CYCLES-1.
- GAP: counter decrements each cycle.
  - When counter==0, the matching ack is high for that one cycle.
  - The next edge → IDLE.
- Timing, with the request sampled high at edge k:
  - notx is low from edge k+1 to edge k+1+PULSE_CYCLES.
  - ack is high in the cycle starting at edge k+PULSE_CYCLES+GAP_CYCLES.
  - busy deasserts at edge k+1+PULSE_CYCLES+GAP_CYCLES.
- Requests are sampled only in IDLE. Request changes while busy are ignored.
- A requester must drop its req in the cycle after its ack. A req still high then is a new request.
- Back-to-back operations are separated by exactly one IDLE cycle.
- A request withdrawn while busy does not abort the operation; ack is still issued.

Optional Feature:
READBACK_CHECK_EN
- Defined:
  - In the ack cycle Q is compared with the expected value: 1 after set, 0 after clear.
  - On mismatch, err goes high at the next edge and stays high until nReset.
  - The operation still completes normally.
- Undefined: Q is ignored and err is tied to 0.

Test Plan:
Defaults (PULSE_CYCLES=4, GAP_CYCLES=2), 10 ns clock.
- Reset then idle 5 cycles → notS=notR=1, busy=0, no acks.
- set_req sampled high at edge k → notS low for exactly 4 cycles from k+1, notR stays 1, set_ack high one cycle at k+6, Q=1, busy low at k+7.
- set_req and clr_req both high after reset → set served first; with both held, clear served next after one IDLE cycle; notS and notR never low together.
- clr_req raised while a set is in PULSE_S → set completes unaffected; clear starts only after IDLE; Q ends 0, each ack pulses exactly once.
- nReset asserted at the second pulse cycle of a set → notS=1 immediately (no clock edge needed), no ack, state IDLE, err=0.
- With READBACK_CHECK_EN, Q forced to 0 during a set → err=1 the cycle after set_ack, stays 1 through a subsequent correct clear, cleared only by nReset.
